alu_e: RTL and testbench
========================

Name:
alu_e

Overview:
- Execute-stage (E) integer ALU of the 5-stage pipelined MIPS CPU.
- Result path is purely combinational: SrcA/SrcB/Shift/ALUop → ALUresult within the same cycle, so E-stage forwarding works without a bubble.
- A one-cycle registered copy of the result and overflow flag is provided for debug/status use by downstream stages.

Parameters:
- none (datapath fixed at 32 bits; opcode fixed at 5 bits)

Ports:
- clk  input  1  system clock; the only clock in the block.
- reset  input  1  synchronous, active-high reset.
- SrcA  input  32  operand A (rs after forwarding); SrcA[4:0] is the variable shift amount.
- SrcB  input  32  operand B (rt or extended immediate after mux); shift source for all shifts.
- Shift  input  5  constant shift amount (instruction shamt field).
- ALUop  input  5  operation select; encoding listed under Behaviour.
- ALUresult  output  32  combinational result.
- Overflow  output  1  combinational signed-overflow flag; valid for ADD/SUB only, 0 otherwise.
- ALUresult_q  output  32  ALUresult registered on rising clk.
- Overflow_q  output  1  Overflow registered on rising clk.

Behaviour:
- ALUop encoding:
  - 0 ADD: A+B, modulo 2^32.
  - 1 SUB: A−B, modulo 2^32.
  - 2 AND: A&B.
  - 3 OR: A|B.
  - 4 XOR: A^B.
  - 5 NOR: ~(A|B).
  - 6 SLT: 1 if $signed(A)<$signed(B), else 0.
  - 7 SLTU: 1 if A<B unsigned, else 0.
  - 8 SLL: B<<Shift.
  - 9 SRL: B>>Shift, logical.
  - 10 SRA: B>>>Shift, arithmetic.
  - 11 SLLV: B<<A[4:0].
  - 12 SRLV: B>>A[4:0], logical.
  - 13 SRAV: B>>>A[4:0], arithmetic.
  - 14 LUI: {B[15:0],16'h0}.
  - 15 PASSA: A.
  - 16 PASSB: B.
  - 17–31: result 32'h0.
- ALUresult and Overflow are pure combinational functions of the current inputs. No dependence on clk/reset; no latches.
- SLT/SLTU results are zero-extended to 32 bits; bit 0 carries the flag.
- Shifts:
  - Shift amount 0 returns B unchanged.
  - Only A[4:0] is used for the variable shifts; A[31:5] is ignored.
  - SRA/SRAV replicate B[31].
- Overflow:
  - ADD: set when A[31]==B[31] and the sum's bit 31 differs from A[31].
  - SUB: set when A[31]!=B[31] and the difference's bit 31 differs from A[31].
  - 0 for all other ops.
  - The result is still the wrapped value; trapping is decided elsewhere.
- Registered outputs:
  - On rising clk with reset=1: ALUresult_q←0, Overflow_q←0.
  - On rising clk otherwise: ALUresult_q←ALUresult, Overflow_q←Overflow.
  - Latency is exactly 1 cycle; reset has priority.
  - Before the first clk edge the registered values are X; the combinational outputs are unaffected by reset.

Test Plan:
- ALUop=0, A=B=32'hFFFFFFFF → ALUresult=32'hFFFFFFFE, Overflow=0. ALUop=0, A=B=32'h7FFFFFFF → ALUresult=32'hFFFFFFFE, Overflow=1.
- ALUop=1, A=32'h80000000, B=1 → ALUresult=32'h7FFFFFFF, Overflow=1. ALUop=1, A=5, B=7 → ALUresult=32'hFFFFFFFE, Overflow=0.
- Logic ops with A=32'hF0F0F0F0, B=32'hFF00FF00:
  - AND → F000F000
  - OR → FFF0FFF0
  - XOR → 0FF00FF0
  - NOR → 000F000F
- ALUop=6 then 7 with A=32'hFFFFFFFF, B=1 → SLT=1, SLTU=0. ALUop=14, B=32'h00001234 → ALUresult=32'h12340000.
- Shifts with B=32'h80000001:
  - SLL, Shift=4 → 00000010
  - SRL, Shift=4 → 08000000
  - SRA, Shift=4 → F8000000
  - SRAV with A=32'hFFFFFFE4 (A[4:0]=4) → F8000000
  - SLL, Shift=0 → 80000001
- Registered path:
  - reset=1 for one edge → ALUresult_q=0, Overflow_q=0.
  - Release reset; apply ADD 1+2 → ALUresult=3 immediately; ALUresult_q=3 after the next edge.
  - Assert reset mid-stream → ALUresult_q=0 at that edge while ALUresult still shows the live combinational value.
  - ALUop=20 → ALUresult=0.

Source files
------------

// File: rtl/alu_e.sv
// Execute-stage integer ALU: combinational result/overflow path for same-cycle
// forwarding, plus a one-cycle registered copy for downstream status use.
module alu_e (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] SrcA,
    input  logic [31:0] SrcB,
    input  logic [4:0]  Shift,
    input  logic [4:0]  ALUop,
    output logic [31:0] ALUresult,
    output logic        Overflow,
    output logic [31:0] ALUresult_q,
    output logic        Overflow_q
);

    typedef enum logic [4:0] {
        OP_ADD   = 5'd0,
        OP_SUB   = 5'd1,
        OP_AND   = 5'd2,
        OP_OR    = 5'd3,
        OP_XOR   = 5'd4,
        OP_NOR   = 5'd5,
        OP_SLT   = 5'd6,
        OP_SLTU  = 5'd7,
        OP_SLL   = 5'd8,
        OP_SRL   = 5'd9,
        OP_SRA   = 5'd10,
        OP_SLLV  = 5'd11,
        OP_SRLV  = 5'd12,
        OP_SRAV  = 5'd13,
        OP_LUI   = 5'd14,
        OP_PASSA = 5'd15,
        OP_PASSB = 5'd16
    } alu_op_t;

    // Two's-complement overflow: operands agree in sign but the result does not.
    function automatic logic add_ovf(input logic [31:0] a, input logic [31:0] b,
                                     input logic [31:0] s);
        return (a[31] == b[31]) && (s[31] != a[31]);
    endfunction

    function automatic logic sub_ovf(input logic [31:0] a, input logic [31:0] b,
                                     input logic [31:0] d);
        return (a[31] != b[31]) && (d[31] != a[31]);
    endfunction

    function automatic logic [31:0] shift_ra(input logic [31:0] b, input logic [4:0] sh);
        logic signed [31:0] bs;
        bs = $signed(b);
        return $unsigned(bs >>> sh);
    endfunction

    logic signed [31:0] a_s;
    logic signed [31:0] b_s;
    logic        [31:0] sum_p0;
    logic        [31:0] diff_p0;
    logic        [4:0]  vsh_p0;
    logic        [31:0] result_p0;
    logic               ovf_p0;
    logic        [31:0] result_p1;
    logic               ovf_p1;

    assign a_s     = $signed(SrcA);
    assign b_s     = $signed(SrcB);
    assign sum_p0  = SrcA + SrcB;
    assign diff_p0 = SrcA - SrcB;
    assign vsh_p0  = SrcA[4:0];

    // Stage p0: combinational execute, visible in the same cycle for forwarding.
    always_comb begin
        result_p0 = 32'h0;
        ovf_p0    = 1'b0;
        case (ALUop)
            OP_ADD: begin
                result_p0 = sum_p0;
                ovf_p0    = add_ovf(SrcA, SrcB, sum_p0);
            end
            OP_SUB: begin
                result_p0 = diff_p0;
                ovf_p0    = sub_ovf(SrcA, SrcB, diff_p0);
            end
            OP_AND:   result_p0 = SrcA & SrcB;
            OP_OR:    result_p0 = SrcA | SrcB;
            OP_XOR:   result_p0 = SrcA ^ SrcB;
            OP_NOR:   result_p0 = ~(SrcA | SrcB);
            OP_SLT:   result_p0 = {31'b0, (a_s < b_s)};
            OP_SLTU:  result_p0 = {31'b0, (SrcA < SrcB)};
            OP_SLL:   result_p0 = SrcB << Shift;
            OP_SRL:   result_p0 = SrcB >> Shift;
            OP_SRA:   result_p0 = shift_ra(SrcB, Shift);
            OP_SLLV:  result_p0 = SrcB << vsh_p0;
            OP_SRLV:  result_p0 = SrcB >> vsh_p0;
            OP_SRAV:  result_p0 = shift_ra(SrcB, vsh_p0);
            OP_LUI:   result_p0 = {SrcB[15:0], 16'h0};
            OP_PASSA: result_p0 = SrcA;
            OP_PASSB: result_p0 = SrcB;
            default:  result_p0 = 32'h0;
        endcase
    end

    assign ALUresult = result_p0;
    assign Overflow  = ovf_p0;

    // Stage p1: registered status copy; reset clears it without touching the live path.
    always_ff @(posedge clk) begin
        if (reset) begin
            result_p1 <= 32'h0;
            ovf_p1    <= 1'b0;
        end else begin
            result_p1 <= result_p0;
            ovf_p1    <= ovf_p0;
        end
    end

    assign ALUresult_q = result_p1;
    assign Overflow_q  = ovf_p1;

endmodule

// File: tb/tb_alu_e.sv
// Bench for alu_e: arithmetic reference model checked every cycle, plus
// hand-computed vectors that pin both the DUT and the model.
module tb_alu_e;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] SrcA, SrcB;
    logic [4:0]  Shift, ALUop;
    logic [31:0] ALUresult, ALUresult_q;
    logic        Overflow, Overflow_q;

    int checks = 0;
    int errors = 0;

    alu_e dut (
        .clk(clk), .reset(reset), .SrcA(SrcA), .SrcB(SrcB), .Shift(Shift),
        .ALUop(ALUop), .ALUresult(ALUresult), .Overflow(Overflow),
        .ALUresult_q(ALUresult_q), .Overflow_q(Overflow_q)
    );

    always #5 clk = ~clk;

    // Reference: integer arithmetic on 64-bit values, returns {overflow, result}.
    function automatic logic [32:0] model(input logic [4:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic [4:0] sh);
        longint sa, sb, s, p;
        logic [63:0] ua, ub, u;
        logic [31:0] r;
        logic        o;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'h0, a};
        ub = {32'h0, b};
        r = 32'h0;
        o = 1'b0;
        case (op)
            5'd0: begin s = sa + sb; u = ua + ub; r = u[31:0];
                        o = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
            5'd1: begin s = sa - sb; u = ua - ub; r = u[31:0];
                        o = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
            5'd2: r = a & b;
            5'd3: r = a | b;
            5'd4: r = a ^ b;
            5'd5: r = ~(a | b);
            5'd6: r = (sa < sb) ? 32'd1 : 32'd0;
            5'd7: r = (ua < ub) ? 32'd1 : 32'd0;
            5'd8, 5'd11: begin
                p = 64'sd1 << ((op == 5'd8) ? sh : a[4:0]);
                u = ub * 64'(p); r = u[31:0];
            end
            5'd9, 5'd12: begin
                p = 64'sd1 << ((op == 5'd9) ? sh : a[4:0]);
                u = ub / 64'(p); r = u[31:0];
            end
            5'd10, 5'd13: begin
                p = 64'sd1 << ((op == 5'd10) ? sh : a[4:0]);
                s = (sb < 0) ? (sb - (p - 1)) / p : sb / p;   // floor division
                r = s[31:0];
            end
            5'd14: begin u = {48'h0, b[15:0]} * 64'd65536; r = u[31:0]; end
            5'd15: r = a;
            5'd16: r = b;
            default: r = 32'h0;
        endcase
        return {o, r};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    // Expected registered value, tracked from the spec's reset/capture rule.
    logic [32:0] exp_q;
    logic        q_known = 1'b0;
    always @(posedge clk) begin
        exp_q   <= reset ? 33'h0 : model(ALUop, SrcA, SrcB, Shift);
        q_known <= 1'b1;
    end

    always @(negedge clk) begin
        logic [32:0] m;
        m = model(ALUop, SrcA, SrcB, Shift);
        chk("cmp_result", ALUresult, m[31:0]);
        chk("cmp_ovf", {31'b0, Overflow}, {31'b0, m[32]});
        if (q_known) begin
            chk("cmp_result_q", ALUresult_q, exp_q[31:0]);
            chk("cmp_ovf_q", {31'b0, Overflow_q}, {31'b0, exp_q[32]});
        end
    end

    task automatic drive(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] sh);
        @(posedge clk);
        #1;
        ALUop = op; SrcA = a; SrcB = b; Shift = sh;
        @(negedge clk);
        #1;
    endtask

    task automatic vec(input string name, input logic [4:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] sh,
                       input logic [31:0] er, input logic eo);
        logic [32:0] m;
        drive(op, a, b, sh);
        chk(name, ALUresult, er);
        chk({name, "_ovf"}, {31'b0, Overflow}, {31'b0, eo});
        m = model(op, a, b, sh);
        chk({name, "_model"}, m[31:0], er);
    endtask

    logic [31:0] ta [4] = '{32'hFFFFFFFF, 32'h7FFFFFFF, 32'h80000000, 32'h12345678};
    logic [31:0] tb [4] = '{32'h00000001, 32'h80000001, 32'h7FFFFFFF, 32'hFFFF0F0F};
    logic [4:0]  ts [4] = '{5'd0, 5'd4, 5'd31, 5'd17};

    initial begin
        reset = 1'b1;
        ALUop = 5'd0; SrcA = 32'h0; SrcB = 32'h0; Shift = 5'd0;
        @(negedge clk);
        chk("reset_q", ALUresult_q, 32'h0);
        chk("reset_ovf_q", {31'b0, Overflow_q}, 32'h0);
        @(posedge clk); #1; reset = 1'b0;

        vec("add_m1", 5'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd0, 32'hFFFFFFFE, 1'b0);
        vec("add_ovf", 5'd0, 32'h7FFFFFFF, 32'h7FFFFFFF, 5'd0, 32'hFFFFFFFE, 1'b1);
        vec("sub_ovf", 5'd1, 32'h80000000, 32'h1, 5'd0, 32'h7FFFFFFF, 1'b1);
        vec("sub_neg", 5'd1, 32'd5, 32'd7, 5'd0, 32'hFFFFFFFE, 1'b0);
        vec("and", 5'd2, 32'hF0F0F0F0, 32'hFF00FF00, 5'd0, 32'hF000F000, 1'b0);
        vec("or", 5'd3, 32'hF0F0F0F0, 32'hFF00FF00, 5'd0, 32'hFFF0FFF0, 1'b0);
        vec("xor", 5'd4, 32'hF0F0F0F0, 32'hFF00FF00, 5'd0, 32'h0FF00FF0, 1'b0);
        vec("nor", 5'd5, 32'hF0F0F0F0, 32'hFF00FF00, 5'd0, 32'h000F000F, 1'b0);
        vec("slt", 5'd6, 32'hFFFFFFFF, 32'h1, 5'd0, 32'h1, 1'b0);
        vec("sltu", 5'd7, 32'hFFFFFFFF, 32'h1, 5'd0, 32'h0, 1'b0);
        vec("lui", 5'd14, 32'h0, 32'h00001234, 5'd0, 32'h12340000, 1'b0);
        vec("sll4", 5'd8, 32'h0, 32'h80000001, 5'd4, 32'h00000010, 1'b0);
        vec("srl4", 5'd9, 32'h0, 32'h80000001, 5'd4, 32'h08000000, 1'b0);
        vec("sra4", 5'd10, 32'h0, 32'h80000001, 5'd4, 32'hF8000000, 1'b0);
        vec("srav4", 5'd13, 32'hFFFFFFE4, 32'h80000001, 5'd9, 32'hF8000000, 1'b0);
        vec("sllv4", 5'd11, 32'hFFFFFFE4, 32'h80000001, 5'd0, 32'h00000010, 1'b0);
        vec("srlv4", 5'd12, 32'h00000024, 32'h80000001, 5'd0, 32'h08000000, 1'b0);
        vec("sll0", 5'd8, 32'h0, 32'h80000001, 5'd0, 32'h80000001, 1'b0);
        vec("passa", 5'd15, 32'hCAFEBABE, 32'h1, 5'd0, 32'hCAFEBABE, 1'b0);
        vec("passb", 5'd16, 32'hCAFEBABE, 32'h1, 5'd0, 32'h00000001, 1'b0);
        vec("op20", 5'd20, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd3, 32'h0, 1'b0);

        // Registered path: latency one, reset clears only the copy.
        vec("add12", 5'd0, 32'd1, 32'd2, 5'd0, 32'd3, 1'b0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("q_add12", ALUresult_q, 32'd3);
        @(posedge clk); #1; reset = 1'b1;
        @(negedge clk);
        chk("q_mid_reset", ALUresult_q, 32'd3);
        @(posedge clk); #1;
        @(negedge clk);
        chk("q_after_reset", ALUresult_q, 32'h0);
        chk("live_during_reset", ALUresult, 32'd3);
        @(posedge clk); #1; reset = 1'b0;

        // Sweep every opcode over a small operand table; the compare process checks each cycle.
        for (int op = 0; op < 32; op++) begin
            for (int k = 0; k < 4; k++) begin
                drive(5'(op), ta[k], tb[(k + op) % 4], ts[(k + op) % 4]);
            end
        end
        @(posedge clk); #1;
        @(negedge clk); #1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
